// File: rtl/nco_core.sv
// rtl/nco_core.sv - numerically controlled oscillator with loadable waveform table
// Phase accumulator drives a sync-read table; step changes take effect only at wrap.
module nco_core #(
  parameter int ACC_W  = 16,
  parameter int STEP_W = 14,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wr_rst_i,
  input  logic [STEP_W-1:0] freq_step_i,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_valid_o,
  output logic              wrap_o,
  output logic              table_full_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_drain_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_step_act;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_step_req;
  logic              w_run;
  logic              r_wrap;

  logic [DATA_W-1:0] r_ram [2**ADDR_W];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              r_full;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_v;
  logic [DATA_W-1:0] r_sample;
  logic              r_sample_v;

  assign w_run      = (r_state == S_RUN);
  assign w_step_req = {{(ACC_W-STEP_W){1'b0}}, freq_step_i};
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_step_act};
  assign w_rd_addr  = r_acc[ACC_W-1 -: ADDR_W];
  // A pointer clear coinciding with a write redirects that write to address 0.
  assign w_wr_addr  = wr_rst_i ? '0 : r_wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en_i) w_state_nxt = S_RUN;
      S_RUN:   if (!en_i) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain_cnt) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The accumulator advances only while running and still enabled; it holds in drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_step_act <= '0;
      r_wrap     <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (r_state == S_IDLE && en_i) begin
        r_acc      <= '0;
        r_step_act <= w_step_req;
      end else if (w_run && en_i) begin
        r_acc  <= w_sum[ACC_W-1:0];
        r_wrap <= w_sum[ACC_W];
        if (w_sum[ACC_W]) r_step_act <= w_step_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_full   <= 1'b0;
    end else if (wr_rst_i) begin
      r_wr_ptr <= we_i ? ADDR_W'(1) : '0;
      r_full   <= 1'b0;
    end else if (we_i) begin
      r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (&r_wr_ptr) r_full <= 1'b1;
    end
  end

  // Table storage carries no reset so it maps onto block RAM; reads return old data.
  always_ff @(posedge clk) begin
    if (we_i) r_ram[w_wr_addr] <= data_i;
    if (w_run) r_rd_data <= r_ram[w_rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v     <= 1'b0;
      r_sample_v <= 1'b0;
      r_sample   <= '0;
    end else begin
      r_rd_v     <= w_run;
      r_sample_v <= r_rd_v;
      if (r_rd_v) r_sample <= r_rd_data;
    end
  end

  assign sample_o       = r_sample;
  assign sample_valid_o = r_sample_v;
  assign wrap_o         = r_wrap;
  assign table_full_o   = r_full;
  assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_nco_core.sv
// tb/tb_nco_core.sv - scoreboard bench for nco_core
// Expected samples are queued as bursts are driven and popped as valid samples appear.
module tb_nco_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_i = 1'b0;
  logic        we_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        wr_rst_i = 1'b0;
  logic [13:0] freq_step_i = '0;
  logic [7:0]  sample_o;
  logic        sample_valid_o;
  logic        wrap_o;
  logic        table_full_o;
  logic        busy_o;

  nco_core dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .we_i(we_i), .data_i(data_i),
    .wr_rst_i(wr_rst_i), .freq_step_i(freq_step_i), .sample_o(sample_o),
    .sample_valid_o(sample_valid_o), .wrap_o(wrap_o),
    .table_full_o(table_full_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tb_ram [256];
  int         tb_wp = 0;
  int         n_valid = 0;
  int         n_wrap = 0;
  int         first_valid_cyc = -1;
  int         first_wrap_cyc = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sample_valid_o) begin
        n_valid++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() > 0) check_eq("sample", sample_o, exp_q.pop_front());
        else check_eq("extra_sample_valid", sample_valid_o, 0);
      end
      if (wrap_o) begin
        n_wrap++;
        if (first_wrap_cyc < 0) first_wrap_cyc = cyc;
      end
    end
  end

  task automatic write_word(input logic [7:0] d, input logic clr);
    we_i = 1'b1; data_i = d; wr_rst_i = clr;
    if (clr) tb_wp = 0;
    tb_ram[tb_wp] = d;
    tb_wp = (tb_wp + 1) % 256;
    @(posedge clk); #1;
    we_i = 1'b0; wr_rst_i = 1'b0;
  endtask

  // Runs en_i high for len cycles; step s1 is presented from cycle chg onward.
  task automatic burst(input int s0, input int s1, input int chg, input int len, input bit redrive);
    logic [15:0] acc;
    logic [15:0] stp;
    logic [16:0] sum;
    logic [7:0]  last;
    int          exp_wraps;
    int          exp_first_wrap;
    int          t0;
    acc = '0; stp = 16'(s0); exp_wraps = 0; exp_first_wrap = -1; last = '0;
    for (int k = 0; k < len; k++) begin
      last = tb_ram[acc[15:8]];
      exp_q.push_back(last);
      if (k < len - 1) begin
        sum = {1'b0, acc} + {1'b0, stp};
        if (sum[16]) begin
          exp_wraps++;
          if (exp_first_wrap < 0) exp_first_wrap = k + 2;
          stp = (chg > 0 && k + 1 >= chg) ? 16'(s1) : 16'(s0);
        end
        acc = sum[15:0];
      end
    end
    n_valid = 0; n_wrap = 0; first_valid_cyc = -1; first_wrap_cyc = -1;
    freq_step_i = 14'(s0); en_i = 1'b1; t0 = cyc;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      if (chg > 0 && i + 1 == chg) freq_step_i = 14'(s1);
    end
    en_i = 1'b0;
    @(posedge clk); #1; en_i = redrive;
    @(negedge clk); check_eq("busy_drain1", busy_o, 1);
    @(posedge clk); #1; en_i = 1'b0;
    @(negedge clk); check_eq("busy_drain2", busy_o, 1);
    @(posedge clk);
    @(negedge clk); check_eq("busy_idle", busy_o, 0);
    repeat (4) @(negedge clk);
    check_eq("valid_count", n_valid, len);
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("wrap_count", n_wrap, exp_wraps);
    check_eq("first_latency", first_valid_cyc - t0, 3);
    if (exp_wraps > 0) check_eq("first_wrap_cycle", first_wrap_cyc - t0, exp_first_wrap);
    check_eq("sample_hold", sample_o, last);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout expired");
    $fatal(1);
  end

  initial begin
    #1;
    check_eq("rst_sample", sample_o, 0);
    check_eq("rst_valid", sample_valid_o, 0);
    check_eq("rst_wrap", wrap_o, 0);
    check_eq("rst_full", table_full_o, 0);
    check_eq("rst_busy", busy_o, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 255; i++) write_word(8'(i), 1'b0);
    check_eq("full_at_255", table_full_o, 0);
    write_word(8'd255, 1'b0);
    check_eq("full_at_256", table_full_o, 1);

    burst(256, 256, 0, 260, 1'b0);
    burst(128, 128, 0, 520, 1'b0);
    burst(0, 0, 0, 20, 1'b0);
    burst(256, 512, 100, 400, 1'b0);
    burst(256, 256, 0, 30, 1'b1);

    for (int k = 0; k < 20; k++) exp_q.push_back(8'(k));
    freq_step_i = 14'd256; en_i = 1'b1;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_sample", sample_o, 0);
    check_eq("midrst_valid", sample_valid_o, 0);
    check_eq("midrst_busy", busy_o, 0);
    check_eq("midrst_full", table_full_o, 0);
    check_eq("midrst_wrap", wrap_o, 0);
    en_i = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    tb_wp = 0;
    burst(256, 256, 0, 5, 1'b0);

    write_word(8'd0, 1'b0);
    write_word(8'd1, 1'b0);
    write_word(8'd2, 1'b0);
    write_word(8'hA5, 1'b1);
    write_word(8'h11, 1'b0);
    check_eq("full_after_clr", table_full_o, 0);
    burst(256, 256, 0, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
